// File: rtl/fft_engine_serial.sv
// Serial radix-2 DIT FFT: loads N samples bit-reversed, runs every butterfly through one unit, unloads N bins.
// Latency: LOG2N*N/2 compute cycles from the last accepted sample to the first output bin.
// Backpressure: in_ready only while loading; each output bin holds stable until out_ready.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_real/in_imag sample stream,
//        out_valid/out_ready/out_real/out_imag/out_last bin stream, busy (high outside LOAD).
module fft_engine_serial #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 3,
  parameter int SCALE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last,
  output logic              busy
);
  localparam int N  = 1 << LOG2N;
  localparam int PW = DATA_W + 17;  // width of a full complex-product sum
  localparam logic signed [PW-1:0] RND = PW'(16384);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t            state_q, state_d;
  logic [LOG2N-1:0]  cnt_q, cnt_d;  // sample index in LOAD, butterfly j in COMPUTE, bin in UNLOAD
  logic [2:0]        stg_q, stg_d;
  logic [DATA_W-1:0] re_q [N];
  logic [DATA_W-1:0] re_d [N];
  logic [DATA_W-1:0] im_q [N];
  logic [DATA_W-1:0] im_d [N];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // First quadrant of 32767*cos(2*pi*i/32); the rest of the 32-entry ROM follows by symmetry.
  function automatic logic signed [15:0] qcos(input logic [4:0] i);
    case (i)
      5'd0:    qcos = 16'sd32767;
      5'd1:    qcos = 16'sd32137;
      5'd2:    qcos = 16'sd30273;
      5'd3:    qcos = 16'sd27245;
      5'd4:    qcos = 16'sd23170;
      5'd5:    qcos = 16'sd18204;
      5'd6:    qcos = 16'sd12539;
      5'd7:    qcos = 16'sd6393;
      default: qcos = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] cos32(input logic [4:0] i);
    if (i <= 5'd8)       cos32 = qcos(i);
    else if (i <= 5'd16) cos32 = -qcos(5'd16 - i);
    else if (i <= 5'd24) cos32 = -qcos(i - 5'd16);
    else                 cos32 = qcos(5'd0 - i);  // 32 - i
  endfunction

  // Butterfly datapath
  logic [LOG2N-1:0]         j, half, k, idx_a, idx_b;
  logic [4:0]               tw_idx;
  logic signed [15:0]       w_re, w_im;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, p_re, p_im;
  logic signed [PW-1:0]     pr_full, pi_full, pr_rnd, pi_rnd;
  logic signed [DATA_W:0]   s_re, s_im, d_re, d_im;
  logic [DATA_W-1:0]        top_re, top_im, bot_re, bot_im;
  logic                     unused_bits;

  always_comb begin
    j      = {1'b0, cnt_q[LOG2N-2:0]};
    half   = LOG2N'(1) << stg_q;
    k      = j & (half - LOG2N'(1));
    idx_a  = ((j >> stg_q) << (stg_q + 3'd1)) | k;
    idx_b  = idx_a | half;
    // e*(32/N) with e = k*N/2^(s+1) reduces to k << (4-s)
    tw_idx = 5'(k) << (3'd4 - stg_q);
    w_re   = cos32(tw_idx);
    w_im   = -cos32(tw_idx - 5'd8);  // -sin
    a_re   = re_q[idx_a];
    a_im   = im_q[idx_a];
    b_re   = re_q[idx_b];
    b_im   = im_q[idx_b];
    pr_full = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im);
    pi_full = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re);
    pr_rnd  = (pr_full + RND) >>> 15;
    pi_rnd  = (pi_full + RND) >>> 15;
    p_re    = pr_rnd[DATA_W-1:0];
    p_im    = pi_rnd[DATA_W-1:0];
    s_re    = {a_re[DATA_W-1], a_re} + {p_re[DATA_W-1], p_re};
    s_im    = {a_im[DATA_W-1], a_im} + {p_im[DATA_W-1], p_im};
    d_re    = {a_re[DATA_W-1], a_re} - {p_re[DATA_W-1], p_re};
    d_im    = {a_im[DATA_W-1], a_im} - {p_im[DATA_W-1], p_im};
    top_re  = (SCALE != 0) ? s_re[DATA_W:1] : s_re[DATA_W-1:0];
    top_im  = (SCALE != 0) ? s_im[DATA_W:1] : s_im[DATA_W-1:0];
    bot_re  = (SCALE != 0) ? d_re[DATA_W:1] : d_re[DATA_W-1:0];
    bot_im  = (SCALE != 0) ? d_im[DATA_W:1] : d_im[DATA_W-1:0];
    unused_bits = ^{pr_rnd[PW-1:DATA_W], pi_rnd[PW-1:DATA_W]};
  end

  // Next state and array update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    re_d    = re_q;
    im_d    = im_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          re_d[bitrev(cnt_q)] = in_real;
          im_d[bitrev(cnt_q)] = in_imag;
          cnt_d = cnt_q + LOG2N'(1);
          if (cnt_q == LOG2N'(N - 1)) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        re_d[idx_a] = top_re;
        im_d[idx_a] = top_im;
        re_d[idx_b] = bot_re;
        im_d[idx_b] = bot_im;
        if (cnt_q == LOG2N'(N / 2 - 1)) begin
          cnt_d = '0;
          if (stg_q == 3'(LOG2N - 1)) begin
            stg_d   = '0;
            state_d = UNLOAD;
          end else begin
            stg_d = stg_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + LOG2N'(1);
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          cnt_d = cnt_q + LOG2N'(1);
          if (cnt_q == LOG2N'(N - 1)) state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        stg_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      stg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
    end
  end

  // Sample array needs no reset: outputs are gated until a full frame has been processed.
  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q != LOAD);
    out_valid = (state_q == UNLOAD);
    out_real  = out_valid ? re_q[cnt_q] : '0;
    out_imag  = out_valid ? im_q[cnt_q] : '0;
    out_last  = out_valid && (cnt_q == LOG2N'(N - 1));
  end
endmodule
